// File: rtl/regfile_pc_pkg.sv
// Shared types and constants for the register file / PC block.
package regfile_pc_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned DataW    = 32;
  localparam int unsigned NumRegs  = 1 << RegAddrW;

  localparam logic [DataW-1:0] DefResetPc = 32'h0000_0000;
  localparam int unsigned      DefPcStep  = 4;

  typedef enum logic [2:0] {
    PhIf  = 3'd0,
    PhId  = 3'd1,
    PhEx  = 3'd2,
    PhMem = 3'd3,
    PhWb  = 3'd4
  } phase_e;

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file: two async read ports, one sync write port, r0 tied to zero.
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_2r1w
  import regfile_pc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic [DataW-1:0]    wdata_i,
  input  logic [RegAddrW-1:0] raddr_a_i,
  input  logic [RegAddrW-1:0] raddr_b_i,
  output logic [DataW-1:0]    rdata_a_o,
  output logic [DataW-1:0]    rdata_b_o
);

  logic [DataW-1:0] mem_q [NumRegs];
  logic             wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write so decode sees it in the commit cycle.
    if (wr_en && (raddr_a_i == waddr_i)) rdata_a_o = wdata_i;
    if (wr_en && (raddr_b_i == waddr_i)) rdata_b_o = wdata_i;
`endif
  end

endmodule

// File: rtl/regfile_pc.sv
// Architectural state: register file, PC and the five-phase instruction loop.
// Build option REGFILE_BYPASS_EN enables register write bypass on the read ports.
module regfile_pc
  import regfile_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefResetPc,
  parameter int unsigned PC_STEP  = DefPcStep
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        reg_update,
  input  logic [31:0] reg_new,
  input  logic [4:0]  rd_addr,
  input  logic        pc_update,
  input  logic [31:0] pc_new,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] pc,
  output logic [2:0]  phase,
  output logic        ir_load,
  output logic        commit
);

  phase_e      phase_q, phase_d;
  logic [31:0] pc_q, pc_d;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^pc_new[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= PhIf;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PhIf:    if (!stall) phase_d = PhId;
      PhId:    if (!stall) phase_d = PhEx;
      PhEx:    if (!stall) phase_d = PhMem;
      PhMem:   if (!stall) phase_d = PhWb;
      PhWb:    if (!stall) phase_d = PhIf;
      // Illegal codes recover to IF regardless of stall.
      default: phase_d = PhIf;
    endcase
  end

  always_comb begin
    phase   = phase_q;
    ir_load = (phase_q == PhIf) && !stall;
    commit  = (phase_q == PhWb) && !stall;
  end

  always_comb begin
    pc_d = pc_q;
    if (commit) begin
      pc_d = pc_update ? {pc_new[31:2], 2'b00} : pc_q + 32'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

  regfile_2r1w u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .we_i      (commit && reg_update),
    .waddr_i   (rd_addr),
    .wdata_i   (reg_new),
    .raddr_a_i (rs_addr),
    .raddr_b_i (rt_addr),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data)
  );

endmodule

// File: tb/tb_regfile_pc.sv
// Directed self-checking bench for regfile_pc.
module tb_regfile_pc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        reg_update;
  logic [31:0] reg_new;
  logic [4:0]  rd_addr;
  logic        pc_update;
  logic [31:0] pc_new;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] pc;
  logic [2:0]  phase;
  logic        ir_load;
  logic        commit;

  int checks   = 0;
  int failures = 0;

  regfile_pc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .reg_update (reg_update),
    .reg_new    (reg_new),
    .rd_addr    (rd_addr),
    .pc_update  (pc_update),
    .pc_new     (pc_new),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .pc         (pc),
    .phase      (phase),
    .ir_load    (ir_load),
    .commit     (commit)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_phase(input logic [2:0] target);
    for (int i = 0; i < 8 && phase !== target; i++) tick();
    checks++;
    if (phase !== target) begin
      failures++;
      $display("FAIL goto_phase got=%0d exp=%0d", phase, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; reg_update = 1'b0; reg_new = '0; rd_addr = '0;
    pc_update = 1'b0; pc_new = '0; rs_addr = 5'd1; rt_addr = 5'd31;
    tick();
    tick();
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
    checks++; if (ir_load !== 1'b1) begin failures++; $display("FAIL reset_ir_load got=%b exp=1", ir_load); end
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL reset_commit got=%b exp=0", commit); end
    checks++; if (rs_data !== 32'h0) begin failures++; $display("FAIL reset_rs got=%h exp=0", rs_data); end
    checks++; if (rt_data !== 32'h0) begin failures++; $display("FAIL reset_rt got=%h exp=0", rt_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    logic [31:0] exp_pc;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_pc = (i < 5) ? 32'h0 : 32'h4;
      checks++;
      if (phase !== 3'(i % 5)) begin
        failures++; $display("FAIL seq_phase cyc=%0d got=%0d exp=%0d", i, phase, i % 5);
      end
      checks++;
      if (commit !== (i % 5 == 4)) begin
        failures++; $display("FAIL seq_commit cyc=%0d got=%b exp=%b", i, commit, (i % 5 == 4));
      end
      checks++;
      if (pc !== exp_pc) begin
        failures++; $display("FAIL seq_pc cyc=%0d got=%h exp=%h", i, pc, exp_pc);
      end
      tick();
    end
    checks++; if (pc !== 32'h8) begin failures++; $display("FAIL seq_pc_end got=%h exp=8", pc); end
  endtask

  task automatic test_reg_write();
    logic [31:0] exp_bypass;
    goto_phase(3'd4);
    reg_update = 1'b1; rd_addr = 5'd5; reg_new = 32'hDEAD_BEEF; rs_addr = 5'd5; rt_addr = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_bypass = 32'hDEAD_BEEF;
`else
    exp_bypass = 32'h0;
`endif
    checks++; if (commit !== 1'b1) begin failures++; $display("FAIL wr_commit got=%b exp=1", commit); end
    checks++;
    if (rs_data !== exp_bypass) begin
      failures++; $display("FAIL wr_same_cycle got=%h exp=%h", rs_data, exp_bypass);
    end
    tick();
    reg_update = 1'b0;
    #1;
    checks++; if (rs_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_rs got=%h exp=deadbeef", rs_data); end
    checks++; if (rt_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_rt got=%h exp=deadbeef", rt_data); end
  endtask

  task automatic test_r0_and_gating();
    logic [31:0] pc_before;
    goto_phase(3'd4);
    reg_update = 1'b1; rd_addr = 5'd0; reg_new = 32'h1234; rs_addr = 5'd0;
    tick();
    reg_update = 1'b0;
    #1;
    checks++; if (rs_data !== 32'h0) begin failures++; $display("FAIL r0_write got=%h exp=0", rs_data); end
    goto_phase(3'd2);
    pc_before = pc;
    reg_update = 1'b1; rd_addr = 5'd7; reg_new = 32'h55; pc_update = 1'b1; pc_new = 32'h500;
    rs_addr = 5'd7;
    #1;
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL ex_commit got=%b exp=0", commit); end
    tick();
    reg_update = 1'b0; pc_update = 1'b0;
    #1;
    checks++; if (rs_data !== 32'h0) begin failures++; $display("FAIL gated_r7 got=%h exp=0", rs_data); end
    checks++; if (pc !== pc_before) begin failures++; $display("FAIL gated_pc got=%h exp=%h", pc, pc_before); end
  endtask

  task automatic test_pc_and_reg();
    goto_phase(3'd4);
    pc_update = 1'b1; pc_new = 32'h0000_0103; reg_update = 1'b1; rd_addr = 5'd3; reg_new = 32'd9;
    tick();
    pc_update = 1'b0; reg_update = 1'b0; rs_addr = 5'd3; rt_addr = 5'd3;
    #1;
    checks++; if (pc !== 32'h100) begin failures++; $display("FAIL redirect_pc got=%h exp=100", pc); end
    checks++; if (rs_data !== 32'd9) begin failures++; $display("FAIL redirect_r3 got=%h exp=9", rs_data); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL redirect_phase got=%0d exp=0", phase); end
  endtask

  task automatic test_stall();
    goto_phase(3'd4);
    stall = 1'b1; pc_update = 1'b1; pc_new = 32'h200;
    #1;
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL stall_commit got=%b exp=0", commit); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (phase !== 3'd4) begin failures++; $display("FAIL stall_phase cyc=%0d got=%0d exp=4", i, phase); end
      checks++;
      if (pc !== 32'h100) begin failures++; $display("FAIL stall_pc cyc=%0d got=%h exp=100", i, pc); end
    end
    stall = 1'b0;
    #1;
    checks++; if (commit !== 1'b1) begin failures++; $display("FAIL unstall_commit got=%b exp=1", commit); end
    tick();
    pc_update = 1'b0;
    #1;
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL unstall_pc got=%h exp=200", pc); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL unstall_phase got=%0d exp=0", phase); end
    stall = 1'b1;
    #1;
    checks++; if (ir_load !== 1'b0) begin failures++; $display("FAIL if_stall_ir_load got=%b exp=0", ir_load); end
    tick();
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL if_stall_phase got=%0d exp=0", phase); end
    stall = 1'b0;
    #1;
    checks++; if (ir_load !== 1'b1) begin failures++; $display("FAIL if_ir_load got=%b exp=1", ir_load); end
  endtask

  task automatic test_wrap();
    goto_phase(3'd4);
    pc_update = 1'b1; pc_new = 32'hFFFF_FFFF;
    tick();
    pc_update = 1'b0;
    #1;
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_setup got=%h exp=fffffffc", pc); end
    goto_phase(3'd4);
    tick();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
  endtask

  task automatic test_reset_mid();
    goto_phase(3'd4);
    pc_update = 1'b1; pc_new = 32'h40;
    tick();
    pc_update = 1'b0;
    goto_phase(3'd3);
    rst_n = 1'b0; stall = 1'b1; rs_addr = 5'd5; rt_addr = 5'd3;
    tick();
    rst_n = 1'b1; stall = 1'b0;
    #1;
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL midrst_phase got=%0d exp=0", phase); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL midrst_pc got=%h exp=0", pc); end
    checks++; if (rs_data !== 32'h0) begin failures++; $display("FAIL midrst_r5 got=%h exp=0", rs_data); end
    checks++; if (rt_data !== 32'h0) begin failures++; $display("FAIL midrst_r3 got=%h exp=0", rt_data); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_reg_write();
    test_r0_and_gating();
    test_pc_and_reg();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
